spi_state_machine: RTL and testbench

SPI_STATE_MACHINE -- requirements
Module: spi_state_machine

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_state_machine.sv | 101 ++++++++++
 tb/tb_spi_state_machine.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and default frame constants for the SPI serializer
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    TRANSFER = 2'd2,
    DONE     = 2'd3
  } spi_state_t;

  localparam int DEFAULT_DATA_WIDTH = 24;
  localparam int DEFAULT_GAP_CYCLES = 2;

endpackage

// File: rtl/spi_state_machine.sv
// rtl/spi_state_machine.sv - free-running SPI mode-0 frame serializer, MSB first
module spi_state_machine
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  spi_sclk,
  output logic                  spi_cs_l,
  output logic                  spi_data,
  output logic [5:0]            counter
);

  // Last sclk edge of a frame is the falling edge at count 2*DATA_WIDTH-1.
  localparam logic [5:0] LAST_EDGE = 6'(2 * DATA_WIDTH - 1);
  localparam int         GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  spi_state_t            state, state_d;
  logic [DATA_WIDTH-1:0] shreg, shreg_d;
  logic [GAP_W-1:0]      gap_cnt, gap_d;
  logic                  sclk_d, cs_d, data_d;
  logic [5:0]            cnt_d;

  // Register every output and all internal state; reset aborts a frame at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      gap_cnt  <= '0;
      spi_sclk <= 1'b0;
      spi_cs_l <= 1'b1;
      spi_data <= 1'b0;
      counter  <= '0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      gap_cnt  <= gap_d;
      spi_sclk <= sclk_d;
      spi_cs_l <= cs_d;
      spi_data <= data_d;
      counter  <= cnt_d;
    end
  end

  // Next-state and next-output logic; data only changes on falling sclk transitions.
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    gap_d   = gap_cnt;
    sclk_d  = spi_sclk;
    cs_d    = spi_cs_l;
    data_d  = spi_data;
    cnt_d   = counter;
    case (state)
      IDLE: begin
        state_d = LOAD;
      end
      LOAD: begin
        shreg_d = data_in;
        cs_d    = 1'b0;
        data_d  = data_in[DATA_WIDTH-1];
        sclk_d  = 1'b0;
        cnt_d   = '0;
        state_d = TRANSFER;
      end
      TRANSFER: begin
        if (counter == LAST_EDGE) begin
          sclk_d  = 1'b0;
          cs_d    = 1'b1;
          data_d  = 1'b0;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = DONE;
        end else begin
          sclk_d = ~spi_sclk;
          cnt_d  = counter + 6'd1;
          if (spi_sclk) begin
            shreg_d = shreg << 1;
            data_d  = shreg[DATA_WIDTH-2];
          end
        end
      end
      DONE: begin
        if (gap_cnt == GAP_LAST) begin
          gap_d   = '0;
          state_d = LOAD;
        end else begin
          gap_d = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_state_machine.sv
// tb/tb_spi_state_machine.sv - directed self-checking bench for spi_state_machine
module tb_spi_state_machine;

  logic        clk;
  logic        reset;
  logic [23:0] data_in;
  logic        spi_sclk;
  logic        spi_cs_l;
  logic        spi_data;
  logic [5:0]  counter;

  int tests;
  int failed;
  int cyc;
  int last_fall;
  int viol;
  logic mon_prev;

  spi_state_machine dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .spi_sclk (spi_sclk),
    .spi_cs_l (spi_cs_l),
    .spi_data (spi_data),
    .counter  (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Flag any rising sclk seen while chip select is not asserted.
  always @(negedge clk) begin
    if (!reset && mon_prev === 1'b0 && spi_sclk === 1'b1 && spi_cs_l !== 1'b0) viol = viol + 1;
    mon_prev = spi_sclk;
  end

  task automatic capture_frame(output logic [31:0] bits, output int edges, output int low_cycles,
                               output int max_cnt, output int end_cnt, output int fall_cyc,
                               output bit timeout);
    int guard;
    logic prev;
    bits = '0; edges = 0; low_cycles = 0; max_cnt = 0; end_cnt = 0; fall_cyc = 0; timeout = 1'b0;
    guard = 0;
    while (spi_cs_l !== 1'b1 && guard < 200) begin @(negedge clk); guard++; end
    while (spi_cs_l !== 1'b0 && guard < 200) begin @(negedge clk); guard++; end
    if (guard >= 200) begin timeout = 1'b1; return; end
    fall_cyc = cyc;
    prev = 1'b0;
    guard = 0;
    while (spi_cs_l === 1'b0 && guard < 200) begin
      low_cycles++;
      if (prev === 1'b0 && spi_sclk === 1'b1) begin
        bits = {bits[30:0], spi_data};
        edges++;
      end
      prev = spi_sclk;
      if (int'(counter) > max_cnt) max_cnt = int'(counter);
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) timeout = 1'b1;
    end_cnt = int'(counter);
  endtask

  task automatic test_reset();
    logic [31:0] bits; int e, lc, mx, ec, fc, rel; bit to;
    data_in = 24'h000D73;
    reset = 1'b1;
    @(negedge clk);
    tests++; if (spi_cs_l !== 1'b1) begin failed++; $display("FAIL reset_cs_l: got %b expected 1", spi_cs_l); end
    tests++; if (spi_sclk !== 1'b0) begin failed++; $display("FAIL reset_sclk: got %b expected 0", spi_sclk); end
    tests++; if (spi_data !== 1'b0) begin failed++; $display("FAIL reset_data: got %b expected 0", spi_data); end
    tests++; if (counter !== 6'd0) begin failed++; $display("FAIL reset_counter: got %0d expected 0", counter); end
    reset = 1'b0;
    rel = cyc;
    capture_frame(bits, e, lc, mx, ec, fc, to);
    tests++; if (to) begin failed++; $display("FAIL reset_timeout: got timeout expected frame"); end
    tests++; if (fc - rel !== 2) begin failed++; $display("FAIL reset_first_load: got %0d cycles expected 2", fc - rel); end
    tests++; if (bits[23:0] !== 24'h000D73) begin failed++; $display("FAIL reset_first_frame: got %h expected 000d73", bits[23:0]); end
    last_fall = fc;
  endtask

  task automatic test_basic();
    logic [31:0] bits; int e, lc, mx, ec, fc; bit to;
    capture_frame(bits, e, lc, mx, ec, fc, to);
    tests++; if (to) begin failed++; $display("FAIL basic_timeout: got timeout expected frame"); end
    tests++; if (bits[23:0] !== 24'h000D73) begin failed++; $display("FAIL basic_bits: got %h expected 000d73", bits[23:0]); end
    tests++; if (e !== 24) begin failed++; $display("FAIL basic_edges: got %0d expected 24", e); end
    tests++; if (lc !== 48) begin failed++; $display("FAIL basic_cs_low: got %0d expected 48", lc); end
    tests++; if (fc - last_fall !== 51) begin failed++; $display("FAIL basic_period: got %0d expected 51", fc - last_fall); end
    last_fall = fc;
  endtask

  task automatic test_small_word();
    logic [31:0] bits; int e, lc, mx, ec, fc; bit to;
    data_in = 24'h000003;
    capture_frame(bits, e, lc, mx, ec, fc, to);
    tests++; if (to) begin failed++; $display("FAIL small_timeout: got timeout expected frame"); end
    tests++; if (bits[23:0] !== 24'h000003) begin failed++; $display("FAIL small_bits: got %h expected 000003", bits[23:0]); end
    tests++; if (e !== 24) begin failed++; $display("FAIL small_edges: got %0d expected 24", e); end
    tests++; if (mx !== 47) begin failed++; $display("FAIL small_max_counter: got %0d expected 47", mx); end
    tests++; if (ec !== 0) begin failed++; $display("FAIL small_counter_wrap: got %0d expected 0", ec); end
  endtask

  task automatic test_data_change();
    logic [31:0] b1, b2; int e, lc, mx, ec, fc; bit to1, to2;
    data_in = 24'hFFFFFF;
    fork
      capture_frame(b1, e, lc, mx, ec, fc, to1);
      begin repeat (20) @(negedge clk); data_in = 24'h000000; end
    join
    capture_frame(b2, e, lc, mx, ec, fc, to2);
    tests++; if (to1 || to2) begin failed++; $display("FAIL change_timeout: got timeout expected frames"); end
    tests++; if (b1[23:0] !== 24'hFFFFFF) begin failed++; $display("FAIL change_current: got %h expected ffffff", b1[23:0]); end
    tests++; if (b2[23:0] !== 24'h000000) begin failed++; $display("FAIL change_next: got %h expected 000000", b2[23:0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits; logic [23:0] word; int e, lc, mx, ec, fc; bit to;
    for (int i = 0; i < 6; i++) begin
      word = 24'($urandom);
      data_in = word;
      capture_frame(bits, e, lc, mx, ec, fc, to);
      tests++;
      if (to || bits[23:0] !== word || e !== 24) begin
        failed++;
        $display("FAIL b2b_word%0d: got %h (%0d edges) expected %h (24 edges)", i, bits[23:0], e, word);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] bits; int e, lc, mx, ec, fc, rel, guard, bad; bit to;
    data_in = 24'h5A5A5A;
    guard = 0;
    while (counter !== 6'd20 && guard < 200) begin @(negedge clk); guard++; end
    tests++; if (guard >= 200) begin failed++; $display("FAIL midreset_reach: got timeout expected counter 20"); end
    #2 reset = 1'b1;
    #1;
    tests++; if (spi_cs_l !== 1'b1) begin failed++; $display("FAIL midreset_cs_l: got %b expected 1", spi_cs_l); end
    tests++; if (spi_sclk !== 1'b0) begin failed++; $display("FAIL midreset_sclk: got %b expected 0", spi_sclk); end
    tests++; if (spi_data !== 1'b0 || counter !== 6'd0) begin failed++; $display("FAIL midreset_data_cnt: got %b/%0d expected 0/0", spi_data, counter); end
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (spi_sclk !== 1'b0 || spi_cs_l !== 1'b1) bad++;
    end
    tests++; if (bad !== 0) begin failed++; $display("FAIL midreset_hold: got %0d active samples expected 0", bad); end
    data_in = 24'hC3C3C3;
    reset = 1'b0;
    rel = cyc;
    capture_frame(bits, e, lc, mx, ec, fc, to);
    tests++; if (to || fc - rel !== 2) begin failed++; $display("FAIL midreset_restart: got %0d cycles expected 2", fc - rel); end
    tests++; if (bits[23:0] !== 24'hC3C3C3 || e !== 24) begin failed++; $display("FAIL midreset_frame: got %h (%0d edges) expected c3c3c3 (24 edges)", bits[23:0], e); end
  endtask

  task automatic test_no_stray_sclk();
    tests++; if (viol !== 0) begin failed++; $display("FAIL stray_sclk: got %0d edges with cs_l high expected 0", viol); end
  endtask

  initial begin
    tests = 0; failed = 0; cyc = 0; viol = 0; last_fall = 0; mon_prev = 1'b0;
    reset = 1'b1; data_in = '0;
    test_reset();
    test_basic();
    test_small_word();
    test_data_change();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_stray_sclk();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
